// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: default sizing, count width helper
// and the operation code decoded from the {push, pop} strobe pair.
package lifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Count must represent 0..DEPTH inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    // Both strobes together mean "replace the top entry".
    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lifo_regfile.sv
// DEPTH x WIDTH flop array backing the LIFO stack.
// Ports:
//   clk      clock
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    read address
//   rdata_c  combinational read data at raddr
// Contents are not reset; the stack never reads an entry it has not written.
module lifo_regfile
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port, used for the pop look-ahead.
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parameterised LIFO stack presenting a registered top-of-stack.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_push   push strobe (with i_pop: replace top)
//   i_pop    pop strobe
//   i_data   data to push / replace
//   o_data   registered top-of-stack, 0 when empty
//   o_empty  no entries held
//   o_full   DEPTH entries held
//   o_count  number of entries held
//   o_err    push-when-full or pop-when-empty detected
// Build option: define LIFO_STICKY_ERR_EN to make o_err sticky until reset;
// otherwise o_err is a one-cycle pulse after each error event.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);

    localparam int unsigned CW = count_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    op_e              op;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             err_evt;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata_c;

    // Entry below the top, so a pop can load o_data in the same edge.
    assign raddr = AW'(o_count - TWO_C);

    lifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (i_clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (i_data),
        .raddr   (raddr),
        .rdata_c (rdata_c)
    );

    // Next count, top-of-stack, write request and error event per operation.
    always_comb begin
        op        = decode_op(i_push, i_pop);
        count_nxt = o_count;
        data_nxt  = o_data;
        err_evt   = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        case (op)
            OP_PUSH: begin
                if (o_full) begin
                    err_evt = 1'b1;
                end else begin
                    we        = 1'b1;
                    waddr     = AW'(o_count);
                    count_nxt = o_count + ONE_C;
                    data_nxt  = i_data;
                end
            end
            OP_POP: begin
                if (o_empty) begin
                    err_evt = 1'b1;
                end else if (o_count == ONE_C) begin
                    count_nxt = '0;
                    data_nxt  = '0;
                end else begin
                    count_nxt = o_count - ONE_C;
                    data_nxt  = rdata_c;
                end
            end
            OP_REPLACE: begin
                // An empty stack turns replace into a push plus an underflow flag.
                we       = 1'b1;
                data_nxt = i_data;
                if (o_empty) begin
                    waddr     = '0;
                    count_nxt = ONE_C;
                    err_evt   = 1'b1;
                end else begin
                    waddr = AW'(o_count - ONE_C);
                end
            end
            default: begin
            end
        endcase
    end

    // Count, flags and top-of-stack register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
            o_data  <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_data  <= data_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == DEPTH_C);
        end
    end

    // Error indication.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else begin
`ifdef LIFO_STICKY_ERR_EN
            o_err <= o_err | err_evt;
`else
            o_err <= err_evt;
`endif
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=8).
module tb_lifo_stack;

`ifdef LIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       err;

    int checks = 0;
    int errors = 0;
    bit seen_err = 1'b0;

    lifo_stack #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (din),
        .o_data  (dout),
        .o_empty (empty),
        .o_full  (full),
        .o_count (count),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected err: the event itself, or an earlier event held in the sticky build.
    task automatic expect_state(input string tag, input int cnt, input logic [7:0] data, input bit evt);
        bit exp_err;
        exp_err  = evt | (STICKY & seen_err);
        seen_err = seen_err | evt;
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".data"},  32'(dout),  32'(data));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, ".full"},  32'(full),  32'(cnt == 8));
        check({tag, ".err"},   32'(err),   32'(exp_err));
    endtask

    task automatic op(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 8'h00;

        // 1. reset state
        #12;
        expect_state("reset", 0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, 1'b0, 8'h00);
        expect_state("idle", 0, 8'h00, 1'b0);

        // 2. fill
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 1'b0, 8'(8'h11 + i));
            expect_state("push", i + 1, 8'(8'h11 + i), 1'b0);
        end

        // 3. overflow
        op(1'b1, 1'b0, 8'hAA);
        expect_state("ovf", 8, 8'h18, 1'b1);
        op(1'b0, 1'b0, 8'h00);
        expect_state("ovf_after", 8, 8'h18, 1'b0);

        // 2b. drain
        for (int i = 7; i >= 1; i--) begin
            op(1'b0, 1'b1, 8'h00);
            expect_state("pop", i, 8'(8'h10 + i), 1'b0);
        end
        op(1'b0, 1'b1, 8'h00);
        expect_state("pop_last", 0, 8'h00, 1'b0);

        // 4. underflow, then replace on empty
        op(1'b0, 1'b1, 8'h00);
        expect_state("udf", 0, 8'h00, 1'b1);
        op(1'b1, 1'b1, 8'h5A);
        expect_state("rep_empty", 1, 8'h5A, 1'b1);
        op(1'b0, 1'b1, 8'h00);
        expect_state("pop_5a", 0, 8'h00, 1'b0);

        // 5. replace top
        op(1'b1, 1'b0, 8'h01);
        op(1'b1, 1'b0, 8'h02);
        expect_state("push02", 2, 8'h02, 1'b0);
        op(1'b1, 1'b1, 8'h33);
        expect_state("rep", 2, 8'h33, 1'b0);
        op(1'b0, 1'b1, 8'h00);
        expect_state("pop_rep", 1, 8'h01, 1'b0);

        // Replace while full: no error, count stays 8
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 8'(8'h40 + i));
        expect_state("refill", 8, 8'h46, 1'b0);
        op(1'b1, 1'b1, 8'hC3);
        expect_state("rep_full", 8, 8'hC3, 1'b0);
        op(1'b0, 1'b1, 8'h00);
        expect_state("pop_rep_full", 7, 8'h45, 1'b0);

        // 6. asynchronous reset at count=5 with a coincident strobe
        op(1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 8'h00);
        expect_state("pre_rst", 5, 8'h43, 1'b0);
        #2;
        push  = 1'b1;
        din   = 8'hFF;
        rst_n = 1'b0;
        seen_err = 1'b0;
        #1;
        expect_state("async_rst", 0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        expect_state("rst_strobe", 0, 8'h00, 1'b0);
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        expect_state("pop_after_rst", 0, 8'h00, 1'b1);
        op(1'b0, 1'b0, 8'h00);
        expect_state("final_idle", 0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
